// File: rtl/tpu_pkg.sv
// Shared TPU constants and the packed row type.
//   TPU_DEPTH      : systolic array columns (lanes per result row)
//   TPU_NORM_WIDTH : width of one normalized lane
//   TPU_FIFO_DEPTH : default number of buffered aligned rows
package tpu_pkg;

    localparam int unsigned TPU_DEPTH      = 4;
    localparam int unsigned TPU_NORM_WIDTH = 8;
    localparam int unsigned TPU_FIFO_DEPTH = 4;

    // Lane c of a row sits at row[c], i.e. bits [TPU_NORM_WIDTH*c +: TPU_NORM_WIDTH].
    typedef logic [TPU_DEPTH-1:0][TPU_NORM_WIDTH-1:0] norm_row_t;

endpackage

// File: rtl/tpu_output_deskew_if.sv
// Bundle between the array's bottom row, the deskew block and the pixel writer.
//   in_valid  : column-0 lane carries element 0 of a new row
//   norm_in   : bottom-row lanes, lane c at [NORM_WIDTH*c +: NORM_WIDTH]
//   row_out   : aligned row at the FIFO head (0 when empty)
//   row_valid : row_out holds a row
//   row_ready : consumer accepts the row on valid && ready
//   row_count : rows currently buffered
//   overflow  : sticky, a completed row was dropped while full
// slave = deskew block, master = producer/consumer side.
interface tpu_output_deskew_if
    import tpu_pkg::*;
#(
    parameter int unsigned DEPTH      = TPU_DEPTH,
    parameter int unsigned NORM_WIDTH = TPU_NORM_WIDTH,
    parameter int unsigned FIFO_DEPTH = TPU_FIFO_DEPTH
);

    logic                               in_valid;
    logic [NORM_WIDTH*DEPTH-1:0]        norm_in;
    logic [NORM_WIDTH*DEPTH-1:0]        row_out;
    logic                               row_valid;
    logic                               row_ready;
    logic [$clog2(FIFO_DEPTH+1)-1:0]    row_count;
    logic                               overflow;

    modport slave (
        input  in_valid, norm_in, row_ready,
        output row_out, row_valid, row_count, overflow
    );

    modport master (
        output in_valid, norm_in, row_ready,
        input  row_out, row_valid, row_count, overflow
    );

endinterface

// File: rtl/sync_row_fifo.sv
// Synchronous FIFO of aligned rows with a registered head word.
//   clk, rst    : clock, synchronous active-high reset
//   i_push      : write request for i_push_data
//   i_pop       : read request (ignored when empty)
//   o_head      : registered head entry, 0 when empty
//   o_valid     : registered non-empty flag
//   o_count     : registered occupancy, 0..DEPTH
//   o_full      : occupancy == DEPTH
// A push while full is accepted only if a pop frees a slot on the same edge.
module sync_row_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_push,
    input  logic [WIDTH-1:0]             i_push_data,
    input  logic                         i_pop,
    output logic [WIDTH-1:0]             o_head,
    output logic                         o_valid,
    output logic [$clog2(DEPTH+1)-1:0]   o_count,
    output logic                         o_full
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_head;
    logic             r_valid;

    logic             w_empty;
    logic             w_full;
    logic             w_pop;
    logic             w_push;
    logic [PW-1:0]    w_rd_nxt;
    logic [CW-1:0]    w_count_nxt;
    logic [WIDTH-1:0] w_head_nxt;

    assign w_empty  = (r_count == '0);
    assign w_full   = (r_count == CW'(DEPTH));
    assign w_pop    = i_pop && !w_empty;
    assign w_push   = i_push && (!w_full || w_pop);
    assign w_rd_nxt = r_rd_ptr + PW'(1);

    // Next occupancy and next head word; the head mirrors mem[rd_ptr] but is kept in its own register.
    always_comb begin
        w_count_nxt = r_count;
        w_head_nxt  = r_head;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + CW'(1);
        end else if (w_pop && !w_push) begin
            w_count_nxt = r_count - CW'(1);
        end
        if (w_pop) begin
            // With a single entry the successor is the incoming row (or nothing).
            if (r_count == CW'(1)) begin
                w_head_nxt = w_push ? i_push_data : '0;
            end else begin
                w_head_nxt = r_mem[w_rd_nxt];
            end
        end else if (w_empty && w_push) begin
            w_head_nxt = i_push_data;
        end
    end

    // Pointer, occupancy and head registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_head   <= '0;
            r_valid  <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)  r_rd_ptr <= w_rd_nxt;
            r_count <= w_count_nxt;
            r_head  <= w_head_nxt;
            r_valid <= (w_count_nxt != '0);
        end
    end

    // Storage array; contents are only read behind a valid pointer, so no reset.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_push_data;
    end

    assign o_head  = r_head;
    assign o_valid = r_valid;
    assign o_count = r_count;
    assign o_full  = w_full;

endmodule

// File: rtl/tpu_output_deskew.sv
// Re-aligns the diagonal result wavefront from the systolic array's bottom row
// into packed rows and queues them for the pixel writer.
//   clk, rst : clock, synchronous active-high reset
//   bus      : tpu_output_deskew_if.slave (in_valid, norm_in, row_ready in;
//              row_out, row_valid, row_count, overflow out)
// Lane c of a row arrives c cycles after its in_valid pulse; it is delayed by
// DEPTH-1-c registers so all lanes meet when lane DEPTH-1 arrives.
module tpu_output_deskew
    import tpu_pkg::*;
#(
    parameter int unsigned DEPTH      = TPU_DEPTH,
    parameter int unsigned NORM_WIDTH = TPU_NORM_WIDTH,
    parameter int unsigned FIFO_DEPTH = TPU_FIFO_DEPTH
) (
    input  logic                clk,
    input  logic                rst,
    tpu_output_deskew_if.slave  bus
);

    localparam int unsigned RW = NORM_WIDTH * DEPTH;

    // w_vld[c] is high in the cycle lane c of some row is valid.
    logic [DEPTH-2:0]                  r_vld;
    logic [DEPTH-1:0]                  w_vld;
    logic [DEPTH-1:0][NORM_WIDTH-1:0]  w_row;

    logic [RW-1:0]                     w_head;
    logic                              w_valid;
    logic                              w_full;
    logic                              r_overflow;

    assign w_vld = {r_vld, bus.in_valid};

    // Shift register of in_valid tracking the wavefront across the lanes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld <= '0;
        end else begin
            r_vld <= w_vld[DEPTH-2:0];
        end
    end

    // Per-lane delay lines; each stage loads only when its row's lane is passing through.
    for (genvar c = 0; c < DEPTH - 1; c++) begin : g_lane
        localparam int N = int'(DEPTH) - 1 - c;
        logic [NORM_WIDTH-1:0] r_dly [N];

        always_ff @(posedge clk) begin
            if (rst) begin
                for (int j = 0; j < N; j++) r_dly[j] <= '0;
            end else begin
                if (w_vld[c]) r_dly[0] <= bus.norm_in[NORM_WIDTH*c +: NORM_WIDTH];
                for (int j = 1; j < N; j++) begin
                    if (w_vld[c+j]) r_dly[j] <= r_dly[j-1];
                end
            end
        end

        assign w_row[c] = r_dly[N-1];
    end

    assign w_row[DEPTH-1] = bus.norm_in[NORM_WIDTH*(DEPTH-1) +: NORM_WIDTH];

    sync_row_fifo #(
        .WIDTH (RW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_vld[DEPTH-1]),
        .i_push_data (w_row),
        .i_pop       (bus.row_ready),
        .o_head      (w_head),
        .o_valid     (w_valid),
        .o_count     (bus.row_count),
        .o_full      (w_full)
    );

    // Sticky drop flag: full implies non-empty, so a pop happens exactly when row_ready is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow <= 1'b0;
        end else if (w_vld[DEPTH-1] && w_full && !bus.row_ready) begin
            r_overflow <= 1'b1;
        end
    end

    assign bus.row_valid = w_valid;
    assign bus.row_out   = w_valid ? w_head : '0;
    assign bus.overflow  = r_overflow;

endmodule

// File: tb/tb_tpu_output_deskew.sv
module tb_tpu_output_deskew;
    import tpu_pkg::*;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    tpu_output_deskew_if bus ();

    tpu_output_deskew dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Row schedule: row r starts (in_valid) in cycle g_start[r] with payload g_rows[r].
    int        g_n;
    int        g_start [8];
    norm_row_t g_rows  [8];

    function automatic logic is_start(input int k);
        for (int r = 0; r < g_n; r++) if (g_start[r] == k) return 1'b1;
        return 1'b0;
    endfunction

    function automatic norm_row_t lanes(input int k, input bit use_x);
        norm_row_t v;
        v = use_x ? 'x : '1;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < g_n; r++)
                if (g_start[r] == k - c) v[c] = g_rows[r][c];
        return v;
    endfunction

    // Drive cycle k's inputs, clock once, and leave the bench 1 time unit after the edge.
    task automatic run_cycle(input int k, input logic rdy, input logic rs, input bit use_x);
        bus.in_valid  = is_start(k);
        bus.norm_in   = lanes(k, use_x);
        bus.row_ready = rdy;
        rst           = rs;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        g_n = 0;
        bus.in_valid  = 1'b1;
        bus.norm_in   = 32'hDEAD_BEEF;
        bus.row_ready = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (bus.row_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b want=0", bus.row_valid); end
        n_cmp++; if (bus.row_out !== 32'h0) begin n_err++; $display("FAIL reset_out got=%h want=00000000", bus.row_out); end
        n_cmp++; if (bus.row_count !== 3'd0) begin n_err++; $display("FAIL reset_count got=%0d want=0", bus.row_count); end
        n_cmp++; if (bus.overflow !== 1'b0) begin n_err++; $display("FAIL reset_overflow got=%b want=0", bus.overflow); end
    endtask

    task automatic test_single_row();
        logic      ev;
        logic [31:0] eo;
        do_reset();
        g_n = 1; g_start[0] = 0; g_rows[0] = 32'h4433_2211;
        for (int k = 0; k < 8; k++) begin
            run_cycle(k, 1'b1, 1'b0, 1'b0);
            ev = (k == 3);
            eo = ev ? 32'h4433_2211 : 32'h0;
            n_cmp++; if (bus.row_valid !== ev) begin n_err++; $display("FAIL single_valid k=%0d got=%b want=%b", k, bus.row_valid, ev); end
            n_cmp++; if (bus.row_out !== eo) begin n_err++; $display("FAIL single_out k=%0d got=%h want=%h", k, bus.row_out, eo); end
            n_cmp++; if (bus.row_count !== 3'(ev)) begin n_err++; $display("FAIL single_count k=%0d got=%0d want=%0d", k, bus.row_count, ev); end
        end
    endtask

    // Four back-to-back ramp rows; use_x fills every off-wavefront lane with X.
    task automatic run_ramp(input bit use_x);
        logic        ev;
        logic [31:0] eo;
        logic [31:0] exp_rows [4];
        exp_rows[0] = 32'h0302_0100; exp_rows[1] = 32'h0706_0504;
        exp_rows[2] = 32'h0B0A_0908; exp_rows[3] = 32'h0F0E_0D0C;
        do_reset();
        g_n = 4;
        for (int r = 0; r < 4; r++) begin
            g_start[r] = r;
            for (int c = 0; c < 4; c++) g_rows[r][c] = 8'(4*r + c);
        end
        for (int k = 0; k < 10; k++) begin
            run_cycle(k, 1'b1, 1'b0, use_x);
            ev = (k >= 3 && k <= 6);
            eo = ev ? exp_rows[k-3] : 32'h0;
            n_cmp++; if (bus.row_valid !== ev) begin n_err++; $display("FAIL ramp_valid x=%0d k=%0d got=%b want=%b", use_x, k, bus.row_valid, ev); end
            n_cmp++; if (bus.row_out !== eo) begin n_err++; $display("FAIL ramp_out x=%0d k=%0d got=%h want=%h", use_x, k, bus.row_out, eo); end
            if (use_x) begin
                n_cmp++; if ($isunknown({bus.row_out, bus.row_valid})) begin n_err++; $display("FAIL xprop k=%0d out=%h valid=%b want=known", k, bus.row_out, bus.row_valid); end
            end
        end
    endtask

    task automatic test_back_to_back();
        run_ramp(1'b0);
    endtask

    task automatic test_x_tolerance();
        run_ramp(1'b1);
    endtask

    task automatic test_overflow();
        int          ec;
        logic        eovf;
        logic [31:0] eo;
        do_reset();
        g_n = 5;
        for (int r = 0; r < 5; r++) begin
            g_start[r] = r;
            g_rows[r]  = {8'(8'hA0 + r), 8'(8'hB0 + r), 8'(8'hC0 + r), 8'(8'hD0 + r)};
        end
        for (int k = 0; k < 9; k++) begin
            run_cycle(k, 1'b0, 1'b0, 1'b0);
            ec   = (k < 3) ? 0 : ((k <= 6) ? k - 2 : 4);
            eovf = (k >= 7);
            eo   = (ec > 0) ? g_rows[0] : 32'h0;
            n_cmp++; if (bus.row_count !== 3'(ec)) begin n_err++; $display("FAIL ovf_count k=%0d got=%0d want=%0d", k, bus.row_count, ec); end
            n_cmp++; if (bus.overflow !== eovf) begin n_err++; $display("FAIL ovf_flag k=%0d got=%b want=%b", k, bus.overflow, eovf); end
            n_cmp++; if (bus.row_out !== eo) begin n_err++; $display("FAIL ovf_head k=%0d got=%h want=%h", k, bus.row_out, eo); end
        end
        // Drain: rows 0..3 leave in order, row 4 never shows up.
        for (int d = 0; d < 6; d++) begin
            run_cycle(100 + d, 1'b1, 1'b0, 1'b0);
            ec = (d < 4) ? 3 - d : 0;
            eo = (d < 3) ? g_rows[d+1] : 32'h0;
            n_cmp++; if (bus.row_count !== 3'(ec)) begin n_err++; $display("FAIL drain_count d=%0d got=%0d want=%0d", d, bus.row_count, ec); end
            n_cmp++; if (bus.row_out !== eo) begin n_err++; $display("FAIL drain_head d=%0d got=%h want=%h", d, bus.row_out, eo); end
            n_cmp++; if (bus.overflow !== 1'b1) begin n_err++; $display("FAIL drain_overflow d=%0d got=%b want=1", d, bus.overflow); end
        end
    endtask

    task automatic test_full_push_pop();
        int          ec;
        logic [31:0] eo;
        do_reset();
        g_n = 5;
        for (int r = 0; r < 5; r++) begin
            g_start[r] = r;
            g_rows[r]  = {8'(8'h50 + r), 8'(8'h60 + r), 8'(8'h70 + r), 8'(8'h80 + r)};
        end
        for (int k = 0; k < 13; k++) begin
            run_cycle(k, (k >= 7), 1'b0, 1'b0);
            case (k)
                3, 4, 5, 6: begin ec = k - 2;  eo = g_rows[0]; end
                7:          begin ec = 4;      eo = g_rows[1]; end
                8:          begin ec = 3;      eo = g_rows[2]; end
                9:          begin ec = 2;      eo = g_rows[3]; end
                10:         begin ec = 1;      eo = g_rows[4]; end
                default:    begin ec = 0;      eo = 32'h0;     end
            endcase
            n_cmp++; if (bus.row_count !== 3'(ec)) begin n_err++; $display("FAIL fullpp_count k=%0d got=%0d want=%0d", k, bus.row_count, ec); end
            n_cmp++; if (bus.row_out !== eo) begin n_err++; $display("FAIL fullpp_head k=%0d got=%h want=%h", k, bus.row_out, eo); end
            n_cmp++; if (bus.overflow !== 1'b0) begin n_err++; $display("FAIL fullpp_overflow k=%0d got=%b want=0", k, bus.overflow); end
        end
    endtask

    task automatic test_reset_mid_row();
        logic        ev;
        logic [31:0] eo;
        do_reset();
        // Row 1 pulses in_valid on the reset edge itself and must vanish too.
        g_n = 3;
        g_start[0] = 0; g_rows[0] = 32'hA3A2_A1A0;
        g_start[1] = 2; g_rows[1] = 32'hC3C2_C1C0;
        g_start[2] = 4; g_rows[2] = 32'hB3B2_B1B0;
        for (int k = 0; k < 10; k++) begin
            run_cycle(k, 1'b1, (k == 2), 1'b0);
            if (k >= 2) begin
                ev = (k == 7);
                eo = ev ? 32'hB3B2_B1B0 : 32'h0;
                n_cmp++; if (bus.row_valid !== ev) begin n_err++; $display("FAIL rstmid_valid k=%0d got=%b want=%b", k, bus.row_valid, ev); end
                n_cmp++; if (bus.row_out !== eo) begin n_err++; $display("FAIL rstmid_out k=%0d got=%h want=%h", k, bus.row_out, eo); end
                n_cmp++; if (bus.row_count !== 3'(ev)) begin n_err++; $display("FAIL rstmid_count k=%0d got=%0d want=%0d", k, bus.row_count, ev); end
                n_cmp++; if (bus.overflow !== 1'b0) begin n_err++; $display("FAIL rstmid_overflow k=%0d got=%b want=0", k, bus.overflow); end
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.norm_in   = '0;
        bus.row_ready = 1'b0;
        g_n = 0;
        test_reset();
        test_single_row();
        test_back_to_back();
        test_overflow();
        test_full_push_pop();
        test_reset_mid_row();
        test_x_tolerance();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/tpu_output_deskew.md
# tpu_output_deskew

Receive-side companion to the 4x4 weight-stationary systolic array. The array emits each result row as a diagonal wavefront on its bottom-row normalized outputs (`pe30_norm_out` … `pe33_norm_out`), one column later per cycle. This block re-aligns each wavefront into one packed row, buffers the rows in a small FIFO, and presents them on a valid/ready interface to the downstream pixel writer.

## Interface
Parameters:
- `DEPTH`, 4: array columns (lanes per row).
- `NORM_WIDTH`, 8: width of each normalized lane.
- `FIFO_DEPTH`, 4: buffered aligned rows; power of two, ≥2.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  column-0 lane carries element 0 of a new row this cycle.
- `norm_in`  in  `NORM_WIDTH*DEPTH`  bottom-row lanes; lane c at bits `[NORM_WIDTH*c +: NORM_WIDTH]` (`pe3c_norm_out`).
- `row_out`  out  `NORM_WIDTH*DEPTH`  aligned row at the FIFO head; lane c holds column c.
- `row_valid`  out  1  `row_out` holds a row.
- `row_ready`  in  1  consumer accepts the row on an edge where `row_valid && row_ready`.
- `row_count`  out  `$clog2(FIFO_DEPTH+1)`  rows currently buffered.
- `overflow`  out  1  sticky; a completed row was dropped because the FIFO was full.

## Operation
- Skew contract: for a row whose `in_valid` pulse is sampled at edge E0, lane c is valid at edge E_c = E0 + c. Only `in_valid` is supplied; lane validity is derived internally.
- Valid tracking: a `DEPTH`-stage shift register of `in_valid`. Stage c gates capture of lane c.
- Alignment: lane c passes through `DEPTH-1-c` delay registers, so all lanes meet at edge E_(DEPTH-1). Lane `DEPTH-1` is taken direct.
- Push: at E_(DEPTH-1), the assembled row is written to the FIFO.
- Back-to-back rows: `in_valid` may be high every cycle. Up to `DEPTH` rows may be in flight at once.
- Ignored input: lane contents outside their valid cycle are ignored, including X values. Such values must never reach `row_out`.
- Pop: occurs on any edge where `row_valid && row_ready`.
- Push while full without a pop: the new row is discarded and `overflow` is set. FIFO contents are untouched.
- Push and pop on the same edge while full: both are performed. No overflow. `row_count` is unchanged.
- Push and pop on the same edge while holding one row: the head advances to the new row. `row_count` stays 1.
- Empty FIFO: `row_valid` is 0 and `row_out` is forced to 0.
- Ordering: strictly FIFO. Rows leave in `in_valid` order.
- `overflow` clears only on `rst`.
- `row_count` range: 0 … `FIFO_DEPTH`. It increments on push-only, decrements on pop-only, and is unchanged otherwise.

## Timing
- Reset values: `row_out`=0, `row_valid`=0, `row_count`=0, `overflow`=0. The valid shift register, delay lines and FIFO pointers are cleared.
- Reset mid-operation: partially aligned rows and buffered rows are discarded. No row from before `rst` ever appears afterwards. `in_valid` sampled on the same edge as `rst` is ignored.
- Latency:
  - `in_valid` sampled at E0 gives `row_valid` high after edge E_(DEPTH-1), i.e. `DEPTH` cycles after the `in_valid` cycle (4 at default).
  - This assumes the FIFO was empty. Otherwise the row queues behind earlier rows.
- Throughput: one row per cycle sustained when `row_ready` is held high.
- Output registers: `row_valid`, `row_count` and `overflow` are registered. `row_out` is the registered head entry, gated by `row_valid`.
- Combinational paths: none from `row_ready` to any output.

## Structure
- Shared package `tpu_pkg` holds:
  - constants `TPU_DEPTH`=4 and `TPU_NORM_WIDTH`=8;
  - typedef `norm_row_t` (packed `DEPTH` × `NORM_WIDTH`).
- The top level contains the valid shift register and the per-lane delay lines, generated with a `for` loop over c.
- One sub-module, `sync_row_fifo`:
  - parameters: width, depth;
  - push/pop handling, `count`, `full` and `empty`;
  - registered head output.

## Test plan
1. Single row: `in_valid` in cycle 0; lanes 0x11, 0x22, 0x33, 0x44 valid in cycles 0, 1, 2, 3 respectively, with 0xFF in all other cycles; `row_ready`=1. Expect `row_valid` in cycle 4 only, `row_out`=0x44332211, `row_count` returns to 0.
2. Four back-to-back rows in cycles 0–3, lane c of row r = 4r+c (the 0…15 ramp); `row_ready`=1. Expect rows 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C in cycles 4–7, with no gaps.
3. Overflow: `row_ready`=0, five rows. Expect `row_count`=4 and `overflow`=1 after the fifth row's push edge. Draining yields rows 0–3 in order; row 4 never appears; `overflow` stays 1.
4. Full with simultaneous push/pop: FIFO full and `row_ready`=1 on the edge a fifth row completes. Expect `overflow`=0, `row_count`=4, and all five rows delivered in order.
5. Reset mid-row: `in_valid` in cycle 0, `rst` in cycle 2. Expect all outputs 0 from cycle 3 and no row emitted. A row started in cycle 4 emerges normally in cycle 8.
6. X tolerance: drive X on lanes outside their valid cycles, as the array does during fill/drain. Expect no X on `row_out` or `row_valid` at any time; values match scenario 2.
